// File: rtl/lcd_dma_fetch_if.sv
// Read-burst request/grant port between the LCD fetch controller (master) and memory (slave).
interface lcd_dma_fetch_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_len;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_addr, bus_len,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_addr, bus_len,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lcd_dma_fetch.sv
// Frame-buffer fetch controller: bursts frame words from memory into the LCD pixel FIFO.
// Optional underrun counter is built only when LCD_DMA_UNDERRUN_EN is defined.
module lcd_dma_fetch #(
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  enable,
  input  logic                  v_sync,
  input  logic [31:0]           base_addr,
  input  logic [19:0]           frame_words,
  input  logic [5:0]            fifo_level,
  input  logic                  lcd_rd_en,
  lcd_dma_fetch_if.master       bus,
  output logic                  fifo_wr_en,
  output logic [31:0]           fifo_wdata,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           underrun_cnt
);

  typedef enum logic [2:0] {StIdle, StArb, StBurst, StDrain, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [19:0] remain_q, remain_d;
  logic [3:0]  beats_q, beats_d;
  logic        restart_q, restart_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_len_q, bus_len_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;

  logic        start;
  logic [3:0]  len;
  logic [7:0]  need;
  logic        fits;
  logic        beats_end;
  logic [19:0] remain_dec;

  assign start      = v_sync && enable;
  assign len        = (remain_q < 20'(BURST_LEN)) ? remain_q[3:0] : 4'(BURST_LEN);
  // wr_en_q is a write the FIFO has not yet counted in fifo_level
  assign need       = 8'(fifo_level) + 8'(wr_en_q) + 8'(len);
  assign fits       = need <= 8'(FIFO_DEPTH);
  assign beats_end  = (beats_q == 4'd0) || (beats_q == 4'd1 && bus.bus_rvalid);
  assign remain_dec = (remain_q != 20'd0) ? remain_q - 20'd1 : 20'd0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (frame_words == 20'd0) ? StDone : StArb;
      end
      StArb: begin
        if (start)                             state_d = (frame_words == 20'd0) ? StDone : StArb;
        else if (bus_req_q && bus.bus_gnt)     state_d = StBurst;
        else if (!enable && !bus_req_q)        state_d = StIdle;
      end
      StBurst: begin
        if (start)          state_d = StDrain;
        else if (beats_end) state_d = (remain_dec == 20'd0) ? StDone :
                                      (!enable ? StIdle : StArb);
      end
      StDrain: begin
        if (beats_end) begin
          if (start)                    state_d = (frame_words == 20'd0) ? StDone : StArb;
          else if (restart_q && enable) state_d = (remain_q == 20'd0) ? StDone : StArb;
          else                          state_d = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    remain_d   = remain_q;
    beats_d    = beats_q;
    restart_d  = restart_q;
    bus_req_d  = bus_req_q;
    bus_addr_d = bus_addr_q;
    bus_len_d  = bus_len_q;
    wr_en_d    = bus.bus_rvalid && (state_q == StBurst);
    wdata_d    = bus.bus_rdata;
    done_d     = (state_q == StDone);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = frame_words;
        end
      end
      StArb: begin
        if (start) begin
          addr_d    = base_addr;
          remain_d  = frame_words;
          bus_req_d = 1'b0;
        end else if (bus_req_q) begin
          if (bus.bus_gnt) begin
            bus_req_d = 1'b0;
            beats_d   = bus_len_q;
          end
        end else if (enable && fits && remain_q != 20'd0) begin
          bus_req_d  = 1'b1;
          bus_addr_d = addr_q;
          bus_len_d  = len;
        end
      end
      StBurst: begin
        if (bus.bus_rvalid && beats_q != 4'd0) beats_d = beats_q - 4'd1;
        if (start) begin
          addr_d    = base_addr;
          remain_d  = frame_words;
          restart_d = 1'b1;
        end else if (bus.bus_rvalid) begin
          remain_d = remain_dec;
          addr_d   = addr_q + 32'd4;
        end
      end
      StDrain: begin
        if (bus.bus_rvalid && beats_q != 4'd0) beats_d = beats_q - 4'd1;
        if (start) begin
          addr_d   = base_addr;
          remain_d = frame_words;
        end
        restart_d = beats_end ? 1'b0 : (restart_q || start);
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q     <= '0;
      remain_q   <= '0;
      beats_q    <= '0;
      restart_q  <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
      bus_len_q  <= '0;
      wr_en_q    <= 1'b0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      beats_q    <= beats_d;
      restart_q  <= restart_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      bus_len_q  <= bus_len_d;
      wr_en_q    <= wr_en_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
    end
  end

  assign bus.bus_req  = bus_req_q;
  assign bus.bus_addr = bus_addr_q;
  assign bus.bus_len  = bus_len_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wdata   = wdata_q;
  assign frame_done   = done_q;
  assign busy         = (state_q != StIdle);

`ifdef LCD_DMA_UNDERRUN_EN
  logic [15:0] underrun_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      underrun_q <= '0;
    end else if (v_sync) begin
      underrun_q <= '0;
    end else if (busy && lcd_rd_en && fifo_level == 6'd0 && underrun_q != 16'hFFFF) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_q;
`else
  logic unused_rd_en;
  assign unused_rd_en = lcd_rd_en;
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_lcd_dma_fetch.sv
// Directed bench for lcd_dma_fetch: bursts, throttling, restart, wrap, empty frame, reset, underrun.
module tb_lcd_dma_fetch;
  logic        HCLK;
  logic        HRESET;
  logic        enable;
  logic        v_sync;
  logic [31:0] base_addr;
  logic [19:0] frame_words;
  logic [5:0]  fifo_level;
  logic        lcd_rd_en;
  logic        fifo_wr_en;
  logic [31:0] fifo_wdata;
  logic        busy;
  logic        frame_done;
  logic [15:0] underrun_cnt;

  lcd_dma_fetch_if bus_if ();

  lcd_dma_fetch #(
    .BURST_LEN  (4),
    .FIFO_DEPTH (32)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .enable       (enable),
    .v_sync       (v_sync),
    .base_addr    (base_addr),
    .frame_words  (frame_words),
    .fifo_level   (fifo_level),
    .lcd_rd_en    (lcd_rd_en),
    .bus          (bus_if),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wdata   (fifo_wdata),
    .busy         (busy),
    .frame_done   (frame_done),
    .underrun_cnt (underrun_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && bus_if.bus_req !== 1'b1; i++) @(negedge HCLK);
    chk("req_seen", {31'd0, bus_if.bus_req}, 32'd1);
  endtask

  task automatic frame_start(input logic [31:0] a, input logic [19:0] n);
    base_addr   = a;
    frame_words = n;
    v_sync      = 1'b1;
    @(negedge HCLK);
    v_sync = 1'b0;
  endtask

  // Grant a request, then return len zero-wait beats and check each FIFO write.
  task automatic burst(input logic [31:0] a, input logic [3:0] l, input logic [31:0] d);
    wait_req();
    chk("bus_addr", bus_if.bus_addr, a);
    chk("bus_len", {28'd0, bus_if.bus_len}, {28'd0, l});
    bus_if.bus_gnt = 1'b1;
    @(negedge HCLK);
    bus_if.bus_gnt = 1'b0;
    chk("req_drop", {31'd0, bus_if.bus_req}, 32'd0);
    for (int i = 0; i < int'(l); i++) begin
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = d + 32'(i);
      @(negedge HCLK);
      chk("wr_en", {31'd0, fifo_wr_en}, 32'd1);
      chk("wdata", fifo_wdata, d + 32'(i));
    end
    bus_if.bus_rvalid = 1'b0;
  endtask

  task automatic expect_done();
    @(negedge HCLK);
    chk("frame_done_hi", {31'd0, frame_done}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    @(negedge HCLK);
    chk("frame_done_lo", {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    HRESET = 1'b1;
    enable = 1'b0;
    v_sync = 1'b0;
    base_addr = '0;
    frame_words = '0;
    fifo_level = '0;
    lcd_rd_en = 1'b0;
    bus_if.bus_gnt = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata = '0;
    #1;
    chk("rst_req", {31'd0, bus_if.bus_req}, 32'd0);
    chk("rst_addr", bus_if.bus_addr, 32'd0);
    chk("rst_len", {28'd0, bus_if.bus_len}, 32'd0);
    chk("rst_wr", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_wdata", fifo_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_underrun", {16'd0, underrun_cnt}, 32'd0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    enable = 1'b1;
    @(negedge HCLK);

    // 10-word frame: bursts of 4, 4, 2
    frame_start(32'h0000_1000, 20'd10);
    chk("req_not_early", {31'd0, bus_if.bus_req}, 32'd0);
    burst(32'h0000_1000, 4'd4, 32'hA000_0000);
    burst(32'h0000_1010, 4'd4, 32'hA000_0010);
    burst(32'h0000_1020, 4'd2, 32'hA000_0020);
    expect_done();

    // Throttle: 29 + 4 > 32 holds the request, 28 + 4 releases it
    fifo_level = 6'd29;
    frame_start(32'h0000_2000, 20'd4);
    for (int i = 0; i < 3; i++) begin
      chk("throttled", {31'd0, bus_if.bus_req}, 32'd0);
      @(negedge HCLK);
    end
    fifo_level = 6'd28;
    @(negedge HCLK);
    chk("unthrottled", {31'd0, bus_if.bus_req}, 32'd1);
    burst(32'h0000_2000, 4'd4, 32'hB000_0000);
    expect_done();
    fifo_level = 6'd0;

    // v_sync on the 2nd beat: last two beats drained, restart at new base
    frame_start(32'h0000_3000, 20'd8);
    wait_req();
    chk("drain_addr", bus_if.bus_addr, 32'h0000_3000);
    bus_if.bus_gnt = 1'b1;
    @(negedge HCLK);
    bus_if.bus_gnt = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata = 32'hC000_0000;
    @(negedge HCLK);
    chk("drain_w0", fifo_wdata, 32'hC000_0000);
    bus_if.bus_rdata = 32'hC000_0001;
    base_addr = 32'h0000_5000;
    frame_words = 20'd4;
    v_sync = 1'b1;
    @(negedge HCLK);
    v_sync = 1'b0;
    chk("drain_w1", {31'd0, fifo_wr_en}, 32'd1);
    bus_if.bus_rdata = 32'hC000_0002;
    @(negedge HCLK);
    chk("drain_nowr2", {31'd0, fifo_wr_en}, 32'd0);
    bus_if.bus_rdata = 32'hC000_0003;
    @(negedge HCLK);
    chk("drain_nowr3", {31'd0, fifo_wr_en}, 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    bus_if.bus_rvalid = 1'b0;
    burst(32'h0000_5000, 4'd4, 32'hD000_0000);
    expect_done();

    // Address wrap across 2^32
    frame_start(32'hFFFF_FFF8, 20'd6);
    burst(32'hFFFF_FFF8, 4'd4, 32'hE000_0000);
    burst(32'h0000_0008, 4'd2, 32'hE000_0004);
    expect_done();

    // Empty frame: no request, frame_done two cycles after v_sync
    base_addr = 32'h0000_7000;
    frame_words = 20'd0;
    v_sync = 1'b1;
    @(negedge HCLK);
    v_sync = 1'b0;
    chk("zero_busy", {31'd0, busy}, 32'd1);
    chk("zero_noreq", {31'd0, bus_if.bus_req}, 32'd0);
    @(negedge HCLK);
    chk("zero_done", {31'd0, frame_done}, 32'd1);
    chk("zero_noreq2", {31'd0, bus_if.bus_req}, 32'd0);
    @(negedge HCLK);
    chk("zero_done_lo", {31'd0, frame_done}, 32'd0);

    // Asynchronous reset mid-burst; stray beats afterwards are ignored
    frame_start(32'h0000_4000, 20'd8);
    wait_req();
    bus_if.bus_gnt = 1'b1;
    @(negedge HCLK);
    bus_if.bus_gnt = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata = 32'hF000_0001;
    @(negedge HCLK);
    @(negedge HCLK);
    chk("pre_rst_wr", {31'd0, fifo_wr_en}, 32'd1);
    #2 HRESET = 1'b1;
    #1;
    chk("arst_wr", {31'd0, fifo_wr_en}, 32'd0);
    chk("arst_wdata", fifo_wdata, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_addr", bus_if.bus_addr, 32'd0);
    chk("arst_len", {28'd0, bus_if.bus_len}, 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("stray_wr", {31'd0, fifo_wr_en}, 32'd0);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    bus_if.bus_rvalid = 1'b0;
    @(negedge HCLK);

    // Underrun: request held ungranted keeps the controller busy
    frame_start(32'h0000_6000, 20'd4);
    lcd_rd_en = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge HCLK);
    lcd_rd_en = 1'b0;
`ifdef LCD_DMA_UNDERRUN_EN
    chk("underrun_5", {16'd0, underrun_cnt}, 32'd5);
`else
    chk("underrun_off", {16'd0, underrun_cnt}, 32'd0);
`endif
    v_sync = 1'b1;
    @(negedge HCLK);
    v_sync = 1'b0;
    enable = 1'b0;
    chk("underrun_clr", {16'd0, underrun_cnt}, 32'd0);
    chk("vsync_arb_drop", {31'd0, bus_if.bus_req}, 32'd0);
    @(negedge HCLK);
    chk("disable_idle", {31'd0, busy}, 32'd0);
    @(negedge HCLK);
    chk("disable_noreq", {31'd0, bus_if.bus_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
